// File: rtl/load_align.sv
// Memory-stage load unit: issues word-aligned cache reads over ready/valid,
// stalls M until data returns, then extracts and extends the addressed lane.
module load_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidM,
    input  logic [2:0]  LoadControlM,
    input  logic [31:0] ALUOutM,
    output logic        dcache_re,
    output logic [31:0] dcache_addr,
    input  logic        dcache_rdy,
    input  logic        dcache_valid,
    input  logic [31:0] dcache_dout,
    output logic        StallLoad,
    output logic        AlignErrM,
    output logic [31:0] ReadDataW,
    output logic        LoadValidW
);
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] read_data_q, read_data_d;
    logic        load_valid_q, load_valid_d;

    logic        is_load, aligned;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    always_comb begin
        is_load = ValidM && (LoadControlM >= LD_LB) && (LoadControlM <= LD_LW);
        unique case (LoadControlM)
            LD_LH, LD_LHU: aligned = ~ALUOutM[0];
            LD_LW:         aligned = (ALUOutM[1:0] == 2'b00);
            default:       aligned = 1'b1;
        endcase
    end

    // Extraction always uses the captured control/offset, never the live M inputs.
    always_comb begin
        lane_byte = 8'h00;
        unique case (off_q)
            2'd0: lane_byte = dcache_dout[7:0];
            2'd1: lane_byte = dcache_dout[15:8];
            2'd2: lane_byte = dcache_dout[23:16];
            2'd3: lane_byte = dcache_dout[31:24];
        endcase
        lane_half = off_q[1] ? dcache_dout[31:16] : dcache_dout[15:0];
        unique case (ctrl_q)
            LD_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            LD_LBU:  load_data = {24'h0, lane_byte};
            LD_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            LD_LHU:  load_data = {16'h0, lane_half};
            default: load_data = dcache_dout;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        read_data_d  = read_data_q;
        load_valid_d = 1'b0;
        dcache_re    = 1'b0;
        dcache_addr  = {waddr_q, 2'b00};
        StallLoad    = 1'b0;
        AlignErrM    = 1'b0;
        unique case (state_q)
            IDLE: begin
                dcache_addr = {ALUOutM[31:2], 2'b00};
                if (is_load && aligned) begin
                    ctrl_d    = LoadControlM;
                    off_d     = ALUOutM[1:0];
                    waddr_d   = ALUOutM[31:2];
                    dcache_re = 1'b1;
                    StallLoad = 1'b1;
                    state_d   = dcache_rdy ? WAIT : REQ;
                end else if (is_load) begin
                    AlignErrM = 1'b1;
                end
            end
            REQ: begin
                dcache_re = 1'b1;
                StallLoad = 1'b1;
                if (dcache_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (dcache_valid) begin
                    read_data_d  = load_data;
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    StallLoad = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            dcache_re = 1'b0;
            StallLoad = 1'b0;
            AlignErrM = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ctrl_q       <= 3'b000;
            off_q        <= 2'b00;
            waddr_q      <= 30'h0;
            read_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            read_data_q  <= read_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    assign ReadDataW  = read_data_q;
    assign LoadValidW = load_valid_q;
endmodule
